// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EX bundle, runs the data-memory req/addr_ok/data_ok
// handshake, extracts load data and forwards results to WB and ID. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 108,
    parameter int MEM_TO_WB_WD = 70
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id,
    output logic                    stallreq_mem,
    output logic                    dm_req,
    output logic                    dm_wr,
    output logic [1:0]              dm_size,
    output logic [3:0]              dm_wstrb,
    output logic [31:0]             dm_addr,
    output logic [31:0]             dm_wdata,
    input  logic                    dm_addr_ok,
    input  logic                    dm_data_ok,
    input  logic [31:0]             dm_rdata,
    output logic                    excp_adel,
    output logic                    excp_ades
);

    typedef enum logic [1:0] {IDLE, DONE_WAIT, WAIT_DATA} state_e;

    state_e                  state_q;
    logic [EX_TO_MEM_WD-1:0] bundle_q;
    logic                    done_q;
    logic [31:0]             ld_buf_q;

    logic [31:0] pc, ex_result, store_data;
    logic        mem_en, mem_we, mem_sext, sel_rf_res, rf_we;
    logic [1:0]  mem_size;
    logic [4:0]  rf_waddr;

    logic        misalign, access, complete, rf_we_g;
    logic [3:0]  wstrb_raw;
    logic [31:0] rdata_src, lane, load_data, rf_wdata;
    logic        unused_stall;

    assign {pc, mem_en, mem_we, mem_size, mem_sext, sel_rf_res, rf_we, rf_waddr,
            ex_result, store_data} = bundle_q;
    assign unused_stall = ^{stall[5], stall[2:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = mem_en & (((mem_size == 2'd1) & ex_result[0]) |
                                (mem_size[1] & (ex_result[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign excp_adel = misalign & ~mem_we;
    assign excp_ades = misalign & mem_we;

    // The completion cycle itself never stalls, so the stage advances as data_ok arrives.
    assign access       = mem_en & ~done_q & ~misalign;
    assign complete     = (state_q != IDLE) & dm_data_ok;
    assign stallreq_mem = access & ~complete;
    assign dm_req       = access & (state_q == IDLE);

    assign dm_wr   = mem_we;
    assign dm_size = mem_size;
    assign dm_addr = ex_result;

    always_comb begin
        wstrb_raw = 4'b1111;
        dm_wdata  = store_data;
        case (mem_size)
            2'd0: begin
                wstrb_raw = 4'b0001 << ex_result[1:0];
                dm_wdata  = {4{store_data[7:0]}};
            end
            2'd1: begin
                wstrb_raw = 4'b0011 << ex_result[1:0];
                dm_wdata  = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign dm_wstrb = (mem_en & mem_we) ? wstrb_raw : '0;

    // After completion the word lives in ld_buf_q so a held stage keeps presenting it.
    assign rdata_src = complete ? dm_rdata : ld_buf_q;
    assign lane      = rdata_src >> {ex_result[1:0], 3'b000};

    always_comb begin
        load_data = rdata_src;
        case (mem_size)
            2'd0:    load_data = {{24{mem_sext & lane[7]}}, lane[7:0]};
            2'd1:    load_data = {{16{mem_sext & lane[15]}}, lane[15:0]};
            default: ;
        endcase
    end

    assign rf_wdata      = sel_rf_res ? load_data : ex_result;
    assign rf_we_g       = rf_we & ~stallreq_mem & ~misalign;
    assign mem_to_wb_bus = {pc, rf_we_g, rf_waddr, rf_wdata};
    assign mem_to_id     = {rf_we_g, rf_waddr, rf_wdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q <= '0;
            state_q  <= IDLE;
            done_q   <= 1'b0;
            ld_buf_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dm_req && dm_addr_ok)
                        state_q <= mem_we ? DONE_WAIT : WAIT_DATA;
                end
                DONE_WAIT: begin
                    if (dm_data_ok) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                WAIT_DATA: begin
                    if (dm_data_ok) begin
                        state_q  <= IDLE;
                        done_q   <= 1'b1;
                        ld_buf_q <= dm_rdata;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A new or bubbled bundle supersedes any completion recorded above.
            if (!stall[3]) begin
                bundle_q <= ex_to_mem_bus;
                done_q   <= 1'b0;
                ld_buf_q <= '0;
            end else if (!stall[4]) begin
                bundle_q <= '0;
                done_q   <= 1'b0;
                ld_buf_q <= '0;
            end
        end
    end

endmodule
